// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, owner and read-latency constants for mem_port_arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_WAIT  = 3'b100
    } state_t;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_L = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;
    // Wide enough to hold RD_LAT_MAX - 1.
    localparam int CNT_W      = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, read-return and RAM-side signals of mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              c_valid;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ready;
    logic              c_rvalid;

    logic              l_valid;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_ready;
    logic              l_rvalid;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              mem_ce;
    logic              mem_oce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  c_valid, c_we, c_addr, c_wdata,
        input  l_valid, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output c_ready, c_rvalid, l_ready, l_rvalid, rdata, busy,
        output mem_ce, mem_oce, mem_wre, mem_addr, mem_wdata
    );

    modport master (
        output c_valid, c_we, c_addr, c_wdata,
        output l_valid, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  c_ready, c_rvalid, l_ready, l_rvalid, rdata, busy,
        input  mem_ce, mem_oce, mem_wre, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select between core and loader requests
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention instead of fixed core-first priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_take,
    input  logic i_c_valid,
    input  logic i_l_valid,
    output logic o_grant_c,
    output logic o_grant_l
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_served;

    assign o_grant_c = i_take && i_c_valid && (!i_l_valid || (r_last_served == OWN_L));
    assign o_grant_l = i_take && i_l_valid && (!i_c_valid || (r_last_served == OWN_C));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_served <= OWN_L;
        end else if (o_grant_c || o_grant_l) begin
            r_last_served <= o_grant_l ? OWN_L : OWN_C;
        end
    end
`else
    logic w_unused;

    assign o_grant_c = i_take && i_c_valid;
    assign o_grant_l = i_take && i_l_valid && !i_c_valid;
    assign w_unused  = clk ^ rst;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises core and loader accesses onto one single-port RAM
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT out of range");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_mem_ce;
    logic              r_mem_wre;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_c_rvalid;
    logic              r_l_rvalid;

    logic              w_take;
    logic              w_grant_c;
    logic              w_grant_l;
    logic              w_grant;
    logic              w_c_ready;
    logic              w_l_ready;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_rd_done;

    assign w_take    = (r_state == ST_IDLE);
    assign w_grant   = w_grant_c || w_grant_l;
    assign w_rd_done = (r_state == ST_WAIT) && (r_cnt == '0);

    mem_arb_pick u_pick (
        .clk       (clk),
        .rst       (rst),
        .i_take    (w_take),
        .i_c_valid (bus.c_valid),
        .i_l_valid (bus.l_valid),
        .o_grant_c (w_grant_c),
        .o_grant_l (w_grant_l)
    );

    always_comb begin
        w_sel_we    = bus.c_we;
        w_sel_addr  = bus.c_addr;
        w_sel_wdata = bus.c_wdata;
        if (w_grant_l) begin
            w_sel_we    = bus.l_we;
            w_sel_addr  = bus.l_addr;
            w_sel_wdata = bus.l_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c_ready   = 1'b0;
        w_l_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_c_ready = w_grant_c;
                w_l_ready = w_grant_l;
                if (w_grant) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = r_mem_wre ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The mem_* registers double as the request latch: loaded on grant, cleared outside ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_owner     <= OWN_C;
            r_mem_ce    <= 1'b0;
            r_mem_wre   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_c_rvalid  <= 1'b0;
            r_l_rvalid  <= 1'b0;
        end else begin
            r_mem_ce    <= w_grant;
            r_mem_wre   <= w_grant && w_sel_we;
            r_mem_addr  <= w_grant ? w_sel_addr : '0;
            r_mem_wdata <= w_grant ? w_sel_wdata : '0;
            if (w_grant) begin
                r_owner <= w_grant_l ? OWN_L : OWN_C;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= CNT_W'(RD_LAT - 1);
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_c_rvalid <= w_rd_done && (r_owner == OWN_C);
            r_l_rvalid <= w_rd_done && (r_owner == OWN_L);
            if (w_rd_done) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.c_ready   = w_c_ready;
    assign bus.l_ready   = w_l_ready;
    assign bus.c_rvalid  = r_c_rvalid;
    assign bus.l_rvalid  = r_l_rvalid;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.mem_ce    = r_mem_ce;
    assign bus.mem_oce   = r_mem_ce;
    assign bus.mem_wre   = r_mem_wre;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
